// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: single outstanding access with
// alignment checks, lane steering and a bus timeout.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_we;
  logic [2:0]    r_size;
  logic [31:0]   r_addr;
  logic [31:0]   r_wd;
  logic [31:0]   r_result;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_fault;
  logic          w_tmo;
  logic [31:0]   w_lane;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;

  // Classify the incoming request: illegal size or misaligned.
  always_comb begin
    w_fault = 1'b0;
    unique case (core_size_i)
      3'd0, 3'd4: w_fault = 1'b0;
      3'd1, 3'd5: w_fault = core_addr_i[0];
      3'd2:       w_fault = |core_addr_i[1:0];
      default:    w_fault = 1'b1;
    endcase
  end

  assign w_tmo  = (r_cnt == CNT_LAST);
  assign w_lane = mem_rd_i >> {r_addr[1:0], 3'b000};

  // Lane steering for byte enables, store data and load result.
  always_comb begin
    w_be   = 4'b1111;
    w_wd   = r_wd;
    w_load = mem_rd_i;
    unique case (r_size)
      3'd0, 3'd4: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wd[7:0]}};
        w_load = r_size[2] ? {24'd0, w_lane[7:0]}
               : {{24{w_lane[7]}}, w_lane[7:0]};
      end
      3'd1, 3'd5: begin
        w_be = 4'b0011 << {r_addr[1], 1'b0};
        w_wd = {2{r_wd[15:0]}};
        w_load = r_size[2] ? {16'd0, w_lane[15:0]}
               : {{16{w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        w_be   = 4'b1111;
        w_wd   = r_wd;
        w_load = mem_rd_i;
      end
    endcase
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (core_req_i)
          w_state_nxt = w_fault ? DONE : BUSY;
      end
      BUSY: begin
        if (mem_ready_i || w_tmo)
          w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request capture, timeout counter and result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_size   <= 3'd0;
      r_addr   <= 32'd0;
      r_wd     <= 32'd0;
      r_result <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (core_req_i && w_fault) begin
            r_err    <= 1'b1;
            r_result <= 32'd0;
          end else if (core_req_i) begin
            r_we   <= core_we_i;
            r_size <= core_size_i;
            r_addr <= core_addr_i;
            r_wd   <= core_wd_i;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            r_err <= 1'b0;
            if (!r_we)
              r_result <= w_load;
          end else if (w_tmo) begin
            r_err    <= 1'b1;
            r_result <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: memory side only live in BUSY.
  always_comb begin
    mem_req_o    = (r_state == BUSY);
    mem_we_o     = mem_req_o & r_we;
    mem_be_o     = mem_req_o ? w_be : 4'd0;
    mem_addr_o   = mem_req_o ? {r_addr[31:2], 2'b00} : 32'd0;
    mem_wd_o     = mem_req_o ? w_wd : 32'd0;
    core_err_o   = (r_state == DONE) & r_err;
    core_rd_o    = r_result;
    core_stall_o = 1'b0;
    unique case (r_state)
      IDLE:    core_stall_o = core_req_i;
      BUSY:    core_stall_o = 1'b1;
      default: core_stall_o = 1'b0;
    endcase
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max BUSY cycles waited for mem_ready_i before bus error.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port core_req_i  input  1  core requests a memory access this cycle.
REQ-005 SHALL have port core_we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have port core_size_i  input  3  funct3 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 SHALL have port core_addr_i  input  32  byte address.
REQ-008 SHALL have port core_wd_i  input  32  store data (register file read port 2 value).
REQ-009 SHALL have port core_rd_o  output  32  formatted load result (register file write data).
REQ-010 SHALL have port core_stall_o  output  1  core must hold PC and request while high.
REQ-011 SHALL have port core_err_o  output  1  access faulted (misaligned, illegal size, timeout).
REQ-012 SHALL have port mem_req_o  output  1  memory request.
REQ-013 SHALL have port mem_we_o  output  1  memory write enable.
REQ-014 SHALL have port mem_be_o  output  4  byte enables.
REQ-015 SHALL have port mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-016 SHALL have port mem_wd_o  output  32  lane-replicated store data.
REQ-017 SHALL have port mem_rd_i  input  32  memory read word.
REQ-018 SHALL have port mem_ready_i  input  1  memory completes request this cycle.

Function
REQ-019 SHALL implement FSM IDLE, BUSY, DONE.
REQ-020 IDLE: on core_req_i=1 with legal aligned access, SHALL register we/size/addr/wd, clear timeout counter, go BUSY.
REQ-021 IDLE: on core_req_i=1 with misaligned access (H/HU addr[0]=1; W addr[1:0]!=0) or illegal size (3,6,7), SHALL go DONE with error flag set, no mem_req_o.
REQ-022 BUSY: mem_req_o=1, mem_we/be/addr/wd driven from registered values, stable until completion.
REQ-023 BUSY with mem_ready_i=1: SHALL capture formatted mem_rd_i (loads) into result register, go DONE, error flag clear.
REQ-024 BUSY, mem_ready_i=0: counter increments; when counter reaches TIMEOUT_CYCLES-1 without ready, SHALL go DONE with error flag set, result 0.
REQ-025 DONE: SHALL return to IDLE unconditionally after one cycle; core_err_o = error flag only in DONE, else 0.
REQ-026 core_stall_o SHALL be core_req_i in IDLE, 1 in BUSY, 0 in DONE (combinational).
REQ-027 core_rd_o SHALL hold result register; updated only on load completion, 0 on faulted access, unchanged by stores.
REQ-028 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-029 Store data: B {4{wd[7:0]}}; H {2{wd[15:0]}}; W wd.
REQ-030 Load format: select lane by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W pass-through.
REQ-031 mem_req_o SHALL be 0 outside BUSY; mem_we_o SHALL be 0 when mem_req_o=0.
REQ-032 mem_ready_i outside BUSY SHALL be ignored.
REQ-033 mem_ready_i=1 on first BUSY cycle SHALL be honoured (minimum access: 1 IDLE + 1 BUSY + 1 DONE cycle).

Reset
REQ-034 rst_ni low SHALL immediately force IDLE, counter 0, result 0, error flag 0, mem_req_o 0, core_err_o 0, core_rd_o 0.
REQ-035 Reset asserted in BUSY SHALL abandon the access; no partial result retained after release.

Verification
REQ-036 LW addr 0x100, mem_rd_i 0xDEADBEEF, ready on 1st BUSY cycle -> mem_be_o 4'hF, stall 1,1,0, core_rd_o 0xDEADBEEF in DONE.
REQ-037 LB addr 0x103, mem_rd_i 0x80FF_0000 -> core_rd_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202, wd 0x1234ABCD -> mem_addr_o 0x200, mem_be_o 4'b1100, mem_wd_o 0xABCDABCD, mem_we_o 1.
REQ-039 LW addr 0x101 -> no mem_req_o, DONE next cycle, core_err_o 1 one cycle, core_rd_o 0.
REQ-040 LW, mem_ready_i held 0 -> exactly TIMEOUT_CYCLES BUSY cycles, then core_err_o 1, stall 0, return IDLE.
REQ-041 rst_ni low during 3rd BUSY cycle -> mem_req_o 0 same cycle, all outputs 0; next request after release completes normally.
